// File: rtl/kv10_shift_unit_pkg.sv
// Shared encodings for the KV10 shift/rotate sequencer.
package kv10_shift_unit_pkg;

  localparam int unsigned KV_WORD = 36;
  localparam int unsigned KV_CNT  = 9;

  typedef enum logic [2:0] {
    SHOP_LSH  = 3'b000,
    SHOP_ASH  = 3'b001,
    SHOP_ROT  = 3'b010,
    SHOP_LSHC = 3'b100,
    SHOP_ASHC = 3'b101,
    SHOP_ROTC = 3'b110
  } shop_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_EXEC1,
    ST_EXEC2,
    ST_DONE
  } state_e;

endpackage

// File: rtl/kv10_shift_unit_if.sv
// Request/response handshake between the execution FSM (master) and the shift unit (slave).
interface kv10_shift_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [35:0] ac;
  logic [35:0] ac1;
  logic [17:0] e;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [35:0] res_ac;
  logic [35:0] res_ac1;
  logic        overflow;
  logic        illegal;

  modport master (
    output req_valid, op, ac, ac1, e, rsp_ready,
    input  req_ready, rsp_valid, res_ac, res_ac1, overflow, illegal
  );

  modport slave (
    input  req_valid, op, ac, ac1, e, rsp_ready,
    output req_ready, rsp_valid, res_ac, res_ac1, overflow, illegal
  );
endinterface

// File: rtl/barrel_shift_36.sv
// Single-word shifter.
module barrel_shift_36 (
  input  logic [35:0] i_din,
  input  logic [8:0]  i_cnt,
  input  logic        i_arith,
  input  logic        i_rotate,
  output logic [35:0] o_dout,
  output logic        o_ovf
);
  barrel_shift_core #(.W(36)) u_core (
    .i_din(i_din), .i_cnt(i_cnt), .i_arith(i_arith), .i_rotate(i_rotate),
    .o_dout(o_dout), .o_ovf(o_ovf)
  );
endmodule

// File: rtl/barrel_shift_72.sv
// Double-word shifter.
module barrel_shift_72 (
  input  logic [71:0] i_din,
  input  logic [8:0]  i_cnt,
  input  logic        i_arith,
  input  logic        i_rotate,
  output logic [71:0] o_dout,
  output logic        o_ovf
);
  barrel_shift_core #(.W(72)) u_core (
    .i_din(i_din), .i_cnt(i_cnt), .i_arith(i_arith), .i_rotate(i_rotate),
    .o_dout(o_dout), .o_ovf(o_ovf)
  );
endmodule

// File: rtl/barrel_shift_core.sv
// Width-generic KV10 shifter: positive count shifts left, negative right.
// Arithmetic left keeps the sign bit and flags loss of significance.
module barrel_shift_core #(
  parameter int unsigned W = 36
) (
  input  logic [W-1:0] i_din,
  input  logic [8:0]   i_cnt,
  input  logic         i_arith,
  input  logic         i_rotate,
  output logic [W-1:0] o_dout,
  output logic         o_ovf
);
  localparam logic [8:0] WL = 9'(W);

  logic           w_right;
  logic [8:0]     w_amt;
  logic [8:0]     w_rmod;
  logic [8:0]     w_rl;
  logic [2*W-1:0] w_ext;

  always_comb begin
    w_right = i_cnt[8];
    w_amt   = w_right ? (~i_cnt + 9'd1) : i_cnt;
    w_rmod  = w_amt % WL;
    // right rotation by r expressed as left rotation by W-r
    w_rl    = (w_right && (w_rmod != '0)) ? (WL - w_rmod) : w_rmod;
    w_ext   = {{W{i_din[W-1]}}, i_din} << w_amt;
    o_ovf   = 1'b0;
    if (i_rotate) begin
      o_dout = (i_din << w_rl) | (i_din >> (WL - w_rl));
    end else if (w_right) begin
      if (i_arith) o_dout = $signed(i_din) >>> w_amt;
      else         o_dout = i_din >> w_amt;
    end else if (i_arith) begin
      o_dout = {i_din[W-1], i_din[W-2:0] << w_amt};
      if (w_amt >= WL) o_ovf = (i_din != '0);
      else             o_ovf = !((&w_ext[2*W-1:W-1]) || !(|w_ext[2*W-1:W-1]));
    end else begin
      o_dout = i_din << w_amt;
    end
  end
endmodule

// File: rtl/kv10_shift_fmt.sv
// Operand formatter: drives both shifters and selects/unpacks the result per op.
module kv10_shift_fmt
  import kv10_shift_unit_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [35:0] i_ac,
  input  logic [35:0] i_ac1,
  input  logic [35:0] i_s36,
  input  logic        i_ovf36,
  input  logic [71:0] i_s72,
  input  logic        i_ovf72,
  output logic [35:0] o_din36,
  output logic        o_arith36,
  output logic        o_rot36,
  output logic [71:0] o_din72,
  output logic        o_arith72,
  output logic        o_rot72,
  output logic [35:0] o_res_ac,
  output logic [35:0] o_res_ac1,
  output logic        o_ovf,
  output logic        o_illegal
);
  always_comb begin
    o_din36   = i_ac;
    o_arith36 = (i_op == SHOP_ASH);
    o_rot36   = (i_op == SHOP_ROT);
    // ASHC: duplicated AC sign in bit 1 so the 70 magnitude bits are contiguous
    o_din72   = (i_op == SHOP_ASHC) ? {i_ac[35], i_ac[35], i_ac[34:0], i_ac1[34:0]}
                                    : {i_ac, i_ac1};
    o_arith72 = (i_op == SHOP_ASHC);
    o_rot72   = (i_op == SHOP_ROTC);
    o_res_ac  = i_ac;
    o_res_ac1 = i_ac1;
    o_ovf     = 1'b0;
    o_illegal = 1'b0;
    case (i_op)
      SHOP_LSH, SHOP_ROT: o_res_ac = i_s36;
      SHOP_ASH: begin
        o_res_ac = i_s36;
        o_ovf    = i_ovf36;
      end
      SHOP_LSHC, SHOP_ROTC: begin
        o_res_ac  = i_s72[71:36];
        o_res_ac1 = i_s72[35:0];
      end
      SHOP_ASHC: begin
        o_res_ac  = {i_s72[71], i_s72[69:35]};
        o_res_ac1 = {i_s72[71], i_s72[34:0]};
        o_ovf     = i_ovf72;
      end
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/kv10_shift_unit.sv
// KV10 shift/rotate sequencer: IDLE -> EXEC (or EXEC1/EXEC2) -> DONE, one op at a time.
module kv10_shift_unit #(
  parameter bit PIPE_SHIFT = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  kv10_shift_unit_if.slave bus
);
  import kv10_shift_unit_pkg::*;

  state_e      r_state;
  logic        r_req_ready, r_rsp_valid;
  logic [2:0]  r_op;
  logic [35:0] r_ac, r_ac1;
  logic [8:0]  r_cnt;
  logic [35:0] r_res_ac, r_res_ac1, r_p_ac, r_p_ac1;
  logic        r_ovf, r_ill, r_p_ovf, r_p_ill;

  logic [8:0]  w_cnt;
  logic        w_e_unused;
  logic [35:0] w_din36, w_s36, w_res_ac, w_res_ac1;
  logic [71:0] w_din72, w_s72;
  logic        w_arith36, w_rot36, w_arith72, w_rot72;
  logic        w_ovf36, w_ovf72, w_ovf, w_ill;

  // count is e[0] (sign) over e[10:17]; middle bits of e carry no meaning
  assign w_cnt      = {bus.e[17], bus.e[7:0]};
  assign w_e_unused = ^bus.e[16:8];

  kv10_shift_fmt u_fmt (
    .i_op(r_op), .i_ac(r_ac), .i_ac1(r_ac1),
    .i_s36(w_s36), .i_ovf36(w_ovf36), .i_s72(w_s72), .i_ovf72(w_ovf72),
    .o_din36(w_din36), .o_arith36(w_arith36), .o_rot36(w_rot36),
    .o_din72(w_din72), .o_arith72(w_arith72), .o_rot72(w_rot72),
    .o_res_ac(w_res_ac), .o_res_ac1(w_res_ac1), .o_ovf(w_ovf), .o_illegal(w_ill)
  );

  barrel_shift_36 u_bs36 (
    .i_din(w_din36), .i_cnt(r_cnt), .i_arith(w_arith36), .i_rotate(w_rot36),
    .o_dout(w_s36), .o_ovf(w_ovf36)
  );

  barrel_shift_72 u_bs72 (
    .i_din(w_din72), .i_cnt(r_cnt), .i_arith(w_arith72), .i_rotate(w_rot72),
    .o_dout(w_s72), .o_ovf(w_ovf72)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_op        <= '0;
      r_ac        <= '0;
      r_ac1       <= '0;
      r_cnt       <= '0;
      r_res_ac    <= '0;
      r_res_ac1   <= '0;
      r_ovf       <= 1'b0;
      r_ill       <= 1'b0;
      r_p_ac      <= '0;
      r_p_ac1     <= '0;
      r_p_ovf     <= 1'b0;
      r_p_ill     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_op        <= bus.op;
            r_ac        <= bus.ac;
            r_ac1       <= bus.ac1;
            r_cnt       <= w_cnt;
            r_req_ready <= 1'b0;
            if (PIPE_SHIFT) r_state <= ST_EXEC1;
            else            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res_ac    <= w_res_ac;
          r_res_ac1   <= w_res_ac1;
          r_ovf       <= w_ovf;
          r_ill       <= w_ill;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_EXEC1: begin
          r_p_ac  <= w_res_ac;
          r_p_ac1 <= w_res_ac1;
          r_p_ovf <= w_ovf;
          r_p_ill <= w_ill;
          r_state <= ST_EXEC2;
        end
        ST_EXEC2: begin
          r_res_ac    <= r_p_ac;
          r_res_ac1   <= r_p_ac1;
          r_ovf       <= r_p_ovf;
          r_ill       <= r_p_ill;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.res_ac    = r_res_ac;
  assign bus.res_ac1   = r_res_ac1;
  assign bus.overflow  = r_ovf;
  assign bus.illegal   = r_ill;
endmodule
